// File: rtl/natalius_port_hub.sv
// Port-I/O hub: decodes the core port bus onto NUM_CH strobe/ack channels,
// stalls the core while a channel is busy, and flags ack timeouts.
module natalius_port_hub #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_CH      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h00,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'hFF,
  parameter int                TIMEOUT     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        port_addr,
  input  logic                     read_e,
  input  logic                     write_e,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     hold,
  output logic [NUM_CH-1:0]        ch_rd,
  output logic [NUM_CH-1:0]        ch_wr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ack,
  output logic                     bus_err
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [IDX_W-1:0]               idx;
  logic                           dir_wr;
  logic [DATA_W-1:0]              wdata_q;
  logic [TMR_W-1:0]               timer;
  logic [3:0]                     err_ch;
  logic [DATA_W-1:0]              status_word;
  logic [NUM_CH-1:0][DATA_W-1:0]  rdata_arr;

  assign rdata_arr = ch_rdata;

  // One extra bit so addresses below BASE_ADDR show up as a negative offset
  logic [ADDR_W:0] offs;
  logic            hit, is_status, request, ack_sel, tmo;
  logic [DATA_W-1:0] rd_sel;

  assign offs      = {1'b0, port_addr} - {1'b0, BASE_ADDR};
  assign hit       = !offs[ADDR_W] && (offs < (ADDR_W+1)'(NUM_CH));
  assign is_status = (port_addr == STATUS_ADDR);
  assign request   = read_e | write_e;
  assign ack_sel   = ch_ack[idx];
  assign rd_sel    = rdata_arr[idx];
  assign tmo       = (timer == TMR_W'(TIMEOUT));

  always_comb begin
    status_word              = '0;
    status_word[DATA_W-1]    = bus_err;
    status_word[3:0]         = err_ch;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (request) state_nx = hit ? ACCESS : DONE;
      ACCESS:  state_nx = ack_sel ? DONE : WAIT;
      WAIT:    if (ack_sel || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      wdata_q   <= '0;
      bus_err   <= 1'b0;
      err_ch    <= '0;
      timer     <= '0;
      idx       <= '0;
      dir_wr    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (request) begin
          if (hit) begin
            idx     <= offs[IDX_W-1:0];
            dir_wr  <= write_e;
            wdata_q <= cpu_wdata;
          end else if (is_status) begin
            if (write_e) begin
              if (cpu_wdata[DATA_W-1]) begin
                bus_err <= 1'b0;
                err_ch  <= '0;
              end
            end else cpu_rdata <= status_word;
          end else if (!write_e) cpu_rdata <= '0;
        end
        ACCESS: begin
          timer <= TMR_W'(1);
          if (ack_sel && !dir_wr) cpu_rdata <= rd_sel;
        end
        WAIT: begin
          // Ack is checked first so a last-cycle ack beats the timeout
          if (ack_sel) begin
            if (!dir_wr) cpu_rdata <= rd_sel;
          end else if (tmo) begin
            bus_err <= 1'b1;
            err_ch  <= 4'(idx);
            if (!dir_wr) cpu_rdata <= '1;
          end else timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign ch_rd[i] = !rst && (state == ACCESS) && !dir_wr && (idx == IDX_W'(i));
    assign ch_wr[i] = !rst && (state == ACCESS) &&  dir_wr && (idx == IDX_W'(i));
  end

  assign ch_wdata = wdata_q;
  assign hold     = !rst && ((state == IDLE && request && hit) ||
                             state == ACCESS || state == WAIT);
endmodule

// File: tb/tb_natalius_port_hub.sv
// Directed bench for natalius_port_hub: a vector table of single transactions
// plus hand-written reset and mid-transaction abort sequences.
module tb_natalius_port_hub;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  port_addr;
  logic        read_e, write_e;
  logic [7:0]  cpu_wdata, cpu_rdata, ch_wdata;
  logic        hold, bus_err;
  logic [3:0]  ch_rd, ch_wr, ch_ack;
  logic [31:0] ch_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  natalius_port_hub dut (
    .clk(clk), .rst(rst), .port_addr(port_addr), .read_e(read_e), .write_e(write_e),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .hold(hold), .ch_rd(ch_rd),
    .ch_wr(ch_wr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ack(ch_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       rd, wr;
    logic [7:0] wdata;
    int         ack_at;
    logic [3:0] ack_mask;
    logic [3:0] e_rd, e_wr;
    int         e_scyc, e_hold, e_done;
    logic [7:0] e_rdata;
    logic       e_err;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [3:0] rd_acc = '0, wr_acc = '0;
    logic [7:0] wd = '0;
    int scyc = 0, hcnt = 0, done = 0;
    logic [7:0] rdv = '0;
    logic       errv = 1'b0;
    @(posedge clk); #1;
    port_addr = v.addr; read_e = v.rd; write_e = v.wr; cpu_wdata = v.wdata; ch_ack = '0;
    #1;
    if (hold) hcnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      read_e = 1'b0; write_e = 1'b0;
      ch_ack = (k == v.ack_at) ? v.ack_mask : 4'b0;
      #1;
      rd_acc |= ch_rd; wr_acc |= ch_wr;
      if ((ch_rd | ch_wr) != 4'b0) scyc++;
      if (ch_wr != 4'b0) wd = ch_wdata;
      if (hold) hcnt++;
      else begin
        done = k; rdv = cpu_rdata; errv = bus_err;
        break;
      end
    end
    ch_ack = '0;
    chk($sformatf("v%0d_ch_rd", id),   32'(rd_acc), 32'(v.e_rd));
    chk($sformatf("v%0d_ch_wr", id),   32'(wr_acc), 32'(v.e_wr));
    chk($sformatf("v%0d_strobe_cycles", id), scyc, v.e_scyc);
    chk($sformatf("v%0d_hold_cycles", id),   hcnt, v.e_hold);
    chk($sformatf("v%0d_done_cycle", id),    done, v.e_done);
    chk($sformatf("v%0d_cpu_rdata", id), 32'(rdv), 32'(v.e_rdata));
    chk($sformatf("v%0d_bus_err", id),   32'(errv), 32'(v.e_err));
    if (v.e_wr != 4'b0) chk($sformatf("v%0d_ch_wdata", id), 32'(wd), 32'(v.wdata));
  endtask

  initial begin
    //          addr   rd wr wdata ack_at mask     e_rd     e_wr    scyc hold done rdata  err
    vt[0]  = '{8'h02, 0, 1, 8'hA5, 1,  4'b0100, 4'b0000, 4'b0100, 1,  2,  2,  8'h00, 0};
    vt[1]  = '{8'h01, 1, 0, 8'h00, 5,  4'b0010, 4'b0010, 4'b0000, 1,  6,  6,  8'h3C, 0};
    vt[2]  = '{8'h00, 1, 0, 8'h00, 1,  4'b0001, 4'b0001, 4'b0000, 1,  2,  2,  8'h44, 0};
    vt[3]  = '{8'h03, 0, 1, 8'h5A, 2,  4'b0001, 4'b0000, 4'b1000, 1,  17, 17, 8'h44, 1};
    vt[4]  = '{8'hFF, 1, 0, 8'h00, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h83, 1};
    vt[5]  = '{8'hFF, 0, 1, 8'h00, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h83, 1};
    vt[6]  = '{8'hFF, 0, 1, 8'h80, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h83, 0};
    vt[7]  = '{8'h02, 1, 0, 8'h00, 3,  4'b0100, 4'b0100, 4'b0000, 1,  4,  4,  8'h22, 0};
    vt[8]  = '{8'h03, 1, 0, 8'h00, 0,  4'b0000, 4'b1000, 4'b0000, 1,  17, 17, 8'hFF, 1};
    vt[9]  = '{8'hFF, 1, 0, 8'h00, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h83, 1};
    vt[10] = '{8'hFF, 0, 1, 8'h80, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h83, 0};
    vt[11] = '{8'h01, 1, 0, 8'h00, 2,  4'b1111, 4'b0010, 4'b0000, 1,  3,  3,  8'h3C, 0};
    vt[12] = '{8'h40, 1, 0, 8'h00, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h00, 0};
    vt[13] = '{8'h40, 0, 1, 8'h99, 0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  1,  8'h00, 0};
    vt[14] = '{8'h00, 1, 1, 8'h77, 1,  4'b0001, 4'b0000, 4'b0001, 1,  2,  2,  8'h00, 0};
    vt[15] = '{8'h00, 1, 0, 8'h00, 16, 4'b0001, 4'b0001, 4'b0000, 1,  17, 17, 8'h44, 0};

    ch_rdata = 32'h1122_3C44;

    // Reset with a pending channel read and noisy acks
    rst = 1'b1; port_addr = 8'h01; read_e = 1'b1; write_e = 1'b1;
    cpu_wdata = 8'($urandom); ch_ack = 4'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold", 32'(hold), 0);
    chk("rst_ch_rd", 32'(ch_rd), 0);
    chk("rst_ch_wr", 32'(ch_wr), 0);
    chk("rst_ch_wdata", 32'(ch_wdata), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    rst = 1'b0; read_e = 1'b0; write_e = 1'b0; ch_ack = '0; cpu_wdata = '0; port_addr = '0;

    for (int i = 0; i < 16; i++) run_vec(vt[i], i);

    // Abort: read ch2, wrong-channel ack in WAIT, then reset mid-WAIT
    @(posedge clk); #1;
    port_addr = 8'h02; read_e = 1'b1; #1;
    chk("abort_hold_req", 32'(hold), 1);
    @(posedge clk); #1;
    read_e = 1'b0; #1;
    chk("abort_ch_rd_access", 32'(ch_rd), 32'(4'b0100));
    @(posedge clk); #1;
    ch_ack = 4'b0001; #1;
    chk("abort_hold_wait", 32'(hold), 1);
    @(posedge clk); #1;
    ch_ack = '0; #1;
    chk("abort_wrong_ack_ignored", 32'(hold), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("abort_hold_after", 32'(hold), 0);
    chk("abort_ch_rd_after", 32'(ch_rd), 0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 0);
    @(posedge clk); #2;
    chk("abort_hold_next", 32'(hold), 0);
    chk("abort_strobes_next", 32'(ch_rd | ch_wr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
